// File: rtl/pkt_sim_pkg.sv
// Shared types, default sizes and the payload-length clamp for the packet simulator.
package pkt_sim_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int CNT_W_DEF   = 32;
    localparam int MAX_LEN_DEF = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // A zero length still sends one word so every accepted frame carries an eof.
    function automatic logic [CNT_W_DEF-1:0] clamp_len(
        input logic [CNT_W_DEF-1:0] len,
        input logic [CNT_W_DEF-1:0] max_len
    );
        if (len == '0) begin
            clamp_len = CNT_W_DEF'(1);
        end else if (len > max_len) begin
            clamp_len = max_len;
        end else begin
            clamp_len = len;
        end
    endfunction

endpackage

// File: rtl/pkt_sim_period_timer.sv
// Free-running period timer; trigger pulses in the first enabled cycle and every period after.
module pkt_sim_period_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sync_rst,
    input  logic [CNT_W-1:0] period,
    output logic             trigger
);

    logic [CNT_W-1:0] tmr_q;
    logic [CNT_W-1:0] tmr_d;
    logic             running;

    assign running = enable && (period != '0) && !sync_rst;

    always_comb begin
        tmr_d = tmr_q;
        if (!running) begin
            tmr_d = '0;
        end else if (tmr_q >= period - CNT_W'(1)) begin
            // ">=" lets a period shrunk below the current count wrap at once
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign trigger = running && (tmr_q == '0);

endmodule

// File: rtl/pkt_sim_scheduler.sv
// Packet-simulator controller: emits one frame of {seq, index} words per period into the TGE port.
module pkt_sim_scheduler
    import pkt_sim_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic              pkt_sim_enable,
    input  logic              pkt_sim_rst,
    input  logic [CNT_W-1:0]  pkt_sim_period,
    input  logic [CNT_W-1:0]  pkt_sim_payload_len,
    input  logic              tx_afull,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_end_of_frame,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  skip_count,
    output logic              busy
);

    logic trigger;
    logic accept;
    logic skip;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  seq_q, seq_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_eof_q, tx_eof_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0]  skip_count_q, skip_count_d;
    logic [CNT_W-1:0]  len_clamped;

    pkt_sim_period_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (user_clk),
        .rst_n    (user_rst_n),
        .enable   (pkt_sim_enable),
        .sync_rst (pkt_sim_rst),
        .period   (pkt_sim_period),
        .trigger  (trigger)
    );

    assign len_clamped = clamp_len(pkt_sim_payload_len, CNT_W'(MAX_LEN));
    // Backpressure is only consulted at frame start; a running frame always finishes.
    assign accept = trigger && (state_q == IDLE) && !tx_afull;
    assign skip   = trigger && ((state_q == SEND) || tx_afull);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        seq_d        = seq_q;
        idx_d        = idx_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        tx_eof_d     = 1'b0;
        pkt_count_d  = pkt_count_q;
        skip_count_d = skip_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d      = len_clamped;
                    seq_d      = pkt_count_q;
                    idx_d      = CNT_W'(1);
                    tx_valid_d = 1'b1;
                    tx_data_d  = {pkt_count_q, {CNT_W{1'b0}}};
                    tx_eof_d   = (len_clamped == CNT_W'(1));
                    state_d    = SEND;
                end
            end
            SEND: begin
                // The word being presented now is the last one: drop back to idle.
                if (tx_eof_q) begin
                    state_d = IDLE;
                end else begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = {seq_q, idx_q};
                    tx_eof_d   = (idx_q == len_q - CNT_W'(1));
                    idx_d      = idx_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (pkt_sim_rst) begin
            pkt_count_d  = '0;
            skip_count_d = '0;
        end else begin
            if (accept) pkt_count_d  = pkt_count_q + CNT_W'(1);
            if (skip)   skip_count_d = skip_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            seq_q        <= '0;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_eof_q     <= 1'b0;
            pkt_count_q  <= '0;
            skip_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_eof_q     <= tx_eof_d;
            pkt_count_q  <= pkt_count_d;
            skip_count_q <= skip_count_d;
        end
    end

    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign tx_end_of_frame = tx_eof_q;
    assign pkt_count       = pkt_count_q;
    assign skip_count      = skip_count_q;
    assign busy            = (state_q == SEND);

endmodule

// File: tb/tb_pkt_sim_scheduler.sv
// Directed bench for pkt_sim_scheduler: frame timing, skips, clamping, backpressure and resets.
module tb_pkt_sim_scheduler;

    logic        user_clk;
    logic        user_rst_n;
    logic        pkt_sim_enable;
    logic        pkt_sim_rst;
    logic [31:0] pkt_sim_period;
    logic [31:0] pkt_sim_payload_len;
    logic        tx_afull;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_end_of_frame;
    logic [31:0] pkt_count;
    logic [31:0] skip_count;
    logic        busy;

    int n_vec;
    int n_err;

    // bit 64 = expected eof, bits 63:0 = expected tx_data
    logic [64:0] exp_q[$];

    pkt_sim_scheduler dut (
        .user_clk            (user_clk),
        .user_rst_n          (user_rst_n),
        .pkt_sim_enable      (pkt_sim_enable),
        .pkt_sim_rst         (pkt_sim_rst),
        .pkt_sim_period      (pkt_sim_period),
        .pkt_sim_payload_len (pkt_sim_payload_len),
        .tx_afull            (tx_afull),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_end_of_frame     (tx_end_of_frame),
        .pkt_count           (pkt_count),
        .skip_count          (skip_count),
        .busy                (busy)
    );

    // clock / reset
    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] seq, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), seq, 32'(i)});
        end
    endtask

    // Scoreboard: every valid word must match the head of exp_q.
    task automatic capture(input int n, input string tag);
        logic [64:0] w;
        for (int c = 0; c < n; c++) begin
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_word"}, tx_data, 64'hffff_ffff_ffff_ffff);
                end else begin
                    w = exp_q.pop_front();
                    check({tag, "_data"}, tx_data, w[63:0]);
                    check({tag, "_eof"}, 64'(tx_end_of_frame), 64'(w[64]));
                end
            end else begin
                if (tx_end_of_frame) check({tag, "_eof_no_valid"}, 64'(tx_end_of_frame), 64'd0);
            end
            step();
        end
    endtask

    task automatic quiesce(input string tag);
        int n;
        n = 0;
        pkt_sim_enable = 1'b0;
        tx_afull       = 1'b0;
        while (busy && n < 3000) begin
            step();
            n++;
        end
        check({tag, "_idle"}, 64'(busy), 64'd0);
        pkt_sim_rst = 1'b1;
        step();
        pkt_sim_rst = 1'b0;
        check({tag, "_pkt_clr"}, 64'(pkt_count), 64'd0);
        check({tag, "_skip_clr"}, 64'(skip_count), 64'd0);
        exp_q.delete();
        step();
    endtask

    initial begin
        int          cnt;
        logic        exp_v;
        logic [31:0] seqv;
        logic [31:0] idx;

        n_vec = 0;
        n_err = 0;
        user_rst_n          = 1'b0;
        pkt_sim_enable      = 1'b0;
        pkt_sim_rst         = 1'b0;
        pkt_sim_period      = 32'd0;
        pkt_sim_payload_len = 32'd0;
        tx_afull            = 1'b0;
        repeat (3) step();
        user_rst_n = 1'b1;
        step();

        check("rst_valid", 64'(tx_valid), 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_eof", 64'(tx_end_of_frame), 64'd0);
        check("rst_pkt", 64'(pkt_count), 64'd0);
        check("rst_skip", 64'(skip_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // len=4, period=10: words in cycles 1-4 (seq 0) and 11-14 (seq 1)
        pkt_sim_period      = 32'd10;
        pkt_sim_payload_len = 32'd4;
        pkt_sim_enable      = 1'b1;
        for (int c = 0; c < 16; c++) begin
            exp_v = (c >= 1 && c <= 4) || (c >= 11 && c <= 14);
            check("p10_valid", 64'(tx_valid), 64'(exp_v));
            if (exp_v) begin
                seqv = (c >= 11) ? 32'd1 : 32'd0;
                idx  = (c >= 11) ? 32'(c - 11) : 32'(c - 1);
                check("p10_data", tx_data, {seqv, idx});
                check("p10_eof", 64'(tx_end_of_frame), 64'(c == 4 || c == 14));
            end
            step();
        end
        check("p10_pkt", 64'(pkt_count), 64'd2);
        check("p10_skip", 64'(skip_count), 64'd0);
        quiesce("p10");

        // len=4, period=3: accepts at 0,6; skips at 3,9
        pkt_sim_period      = 32'd3;
        pkt_sim_payload_len = 32'd4;
        pkt_sim_enable      = 1'b1;
        repeat (12) step();
        pkt_sim_enable = 1'b0;
        check("p3_pkt", 64'(pkt_count), 64'd2);
        check("p3_skip", 64'(skip_count), 64'd2);
        quiesce("p3");

        // len=0 clamps to one word with valid+eof; seq restarts at 0 after pkt_sim_rst
        pkt_sim_period      = 32'd10;
        pkt_sim_payload_len = 32'd0;
        pkt_sim_enable      = 1'b1;
        check("len0_c0_valid", 64'(tx_valid), 64'd0);
        step();
        check("len0_valid", 64'(tx_valid), 64'd1);
        check("len0_eof", 64'(tx_end_of_frame), 64'd1);
        check("len0_data", tx_data, 64'd0);
        check("len0_busy", 64'(busy), 64'd1);
        step();
        check("len0_c2_valid", 64'(tx_valid), 64'd0);
        check("len0_c2_busy", 64'(busy), 64'd0);
        quiesce("len0");

        // len=5000 clamps to 1024 words
        pkt_sim_period      = 32'd2000;
        pkt_sim_payload_len = 32'd5000;
        pkt_sim_enable      = 1'b1;
        step();
        pkt_sim_enable = 1'b0;
        push_frame(32'd0, 1024);
        capture(1030, "len5000");
        check("len5000_left", 64'(exp_q.size()), 64'd0);
        quiesce("len5000");

        // tx_afull at trigger: skip, then next trigger at cycle 6 is accepted
        pkt_sim_period      = 32'd6;
        pkt_sim_payload_len = 32'd2;
        pkt_sim_enable      = 1'b1;
        tx_afull            = 1'b1;
        step();
        tx_afull = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            if (tx_valid) cnt++;
            step();
        end
        check("afull_gap_words", 64'(cnt), 64'd0);
        check("afull_valid", 64'(tx_valid), 64'd1);
        check("afull_data0", tx_data, 64'd0);
        check("afull_skip", 64'(skip_count), 64'd1);
        check("afull_pkt", 64'(pkt_count), 64'd1);
        step();
        check("afull_data1", tx_data, 64'd1);
        check("afull_eof1", 64'(tx_end_of_frame), 64'd1);
        quiesce("afull");

        // tx_afull rising at word 1 of an 8-word frame does not cut it short
        pkt_sim_period      = 32'd20;
        pkt_sim_payload_len = 32'd8;
        pkt_sim_enable      = 1'b1;
        push_frame(32'd0, 8);
        capture(2, "afull_mid");
        tx_afull = 1'b1;
        capture(14, "afull_mid");
        check("afull_mid_left", 64'(exp_q.size()), 64'd0);
        check("afull_mid_skip", 64'(skip_count), 64'd0);
        quiesce("afull_mid");

        // period=0 never issues a frame
        pkt_sim_period      = 32'd0;
        pkt_sim_payload_len = 32'd4;
        pkt_sim_enable      = 1'b1;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (tx_valid) cnt++;
            step();
        end
        check("per0_words", 64'(cnt), 64'd0);
        check("per0_pkt", 64'(pkt_count), 64'd0);
        quiesce("per0");

        // enable dropped at word 2 of 6: frame completes, then nothing more
        pkt_sim_period      = 32'd8;
        pkt_sim_payload_len = 32'd6;
        pkt_sim_enable      = 1'b1;
        push_frame(32'd0, 6);
        capture(3, "en_drop");
        pkt_sim_enable = 1'b0;
        capture(18, "en_drop");
        check("en_drop_left", 64'(exp_q.size()), 64'd0);
        check("en_drop_pkt", 64'(pkt_count), 64'd1);
        check("en_drop_busy", 64'(busy), 64'd0);
        quiesce("en_drop");

        // user_rst_n mid-frame: outputs clear at once, first frame afterwards is seq 0
        pkt_sim_period      = 32'd20;
        pkt_sim_payload_len = 32'd8;
        pkt_sim_enable      = 1'b1;
        repeat (3) step();
        check("arst_pre_valid", 64'(tx_valid), 64'd1);
        check("arst_pre_pkt", 64'(pkt_count), 64'd1);
        #1 user_rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(tx_valid), 64'd0);
        check("arst_data", tx_data, 64'd0);
        check("arst_eof", 64'(tx_end_of_frame), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_pkt", 64'(pkt_count), 64'd0);
        step();
        step();
        user_rst_n = 1'b1;
        check("arst_rel_valid", 64'(tx_valid), 64'd0);
        step();
        check("arst_w0_valid", 64'(tx_valid), 64'd1);
        check("arst_w0_data", tx_data, 64'd0);
        step();
        check("arst_w1_data", tx_data, 64'd1);
        check("arst_w1_pkt", 64'(pkt_count), 64'd1);
        quiesce("arst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_sim_scheduler.md
Name: pkt_sim_scheduler

Overview:
- Packet-simulator controller for the 10GbE tutorial design. It sits in the user_clk domain between the software registers (pkt_sim_period, payload length, enable, counter reset) and the TGE transmit port.
- It issues one frame of test words every pkt_sim_period cycles and obeys TGE almost-full backpressure at frame start.
- It counts sent frames and skipped (dropped) frames for software readback.

Parameters:
- DATA_W, 64, TGE transmit word width; must equal 2*CNT_W.
- CNT_W, 32, width of period timer, sequence and status counters.
- MAX_LEN, 1024, maximum frame length in words; payload length is clamped to this.

Ports:
- user_clk  in  1  sole clock
- user_rst_n  in  1  asynchronous active-low reset
- pkt_sim_enable  in  1  level; generation enabled while high
- pkt_sim_rst  in  1  level, synchronous; clears timer and status counters
- pkt_sim_period  in  CNT_W  frame period in cycles; 0 means no frames
- pkt_sim_payload_len  in  CNT_W  frame length in words
- tx_afull  in  1  TGE transmit FIFO almost full
- tx_data  out  DATA_W  transmit word
- tx_valid  out  1  tx_data valid this cycle
- tx_end_of_frame  out  1  last word of frame; only high together with tx_valid
- pkt_count  out  CNT_W  frames accepted
- skip_count  out  CNT_W  triggers dropped
- busy  out  1  frame in progress

Behaviour:
- Reset (user_rst_n low) is asynchronous.
  - All outputs go to 0 immediately; timer = 0; state = IDLE.
  - A frame in flight is truncated (TGE is reset alongside it).
- Period timer tmr:
  - If pkt_sim_rst is high, or pkt_sim_enable is low, or pkt_sim_period == 0: tmr <= 0.
  - Otherwise tmr <= (tmr >= pkt_sim_period-1) ? 0 : tmr+1.
  - The ">=" comparison means a shrunken period wraps on the next cycle.
- trigger = pkt_sim_enable & (pkt_sim_period != 0) & ~pkt_sim_rst & (tmr == 0).
  - The first trigger fires in the first enabled cycle.
- Accept: trigger & state==IDLE & ~tx_afull.
  - Latch len_q = clamp(pkt_sim_payload_len): 0 -> 1, > MAX_LEN -> MAX_LEN.
  - Latch seq_q = pkt_count.
  - pkt_count <= pkt_count+1.
  - state -> SEND.
- Skip: trigger & (state==SEND | tx_afull). Then skip_count <= skip_count+1.
- Counter arithmetic: pkt_count and skip_count wrap modulo 2^CNT_W.
- States:
  - IDLE -> SEND on accept.
  - SEND -> IDLE on the clock edge after the last word is presented.
- Timing: with accept in cycle T:
  - Word i (0..len_q-1) is presented in cycle T+1+i, with tx_valid = 1 and tx_data = {seq_q[CNT_W-1:0], i[CNT_W-1:0]}.
  - tx_end_of_frame = 1 only at i = len_q-1.
  - state == IDLE from cycle T+len_q+1.
- Consequence: pkt_sim_period >= len_q+1 never skips; a one-cycle gap remains between frames.
- tx_valid, tx_data and tx_end_of_frame are registered.
  - tx_data holds its last value when tx_valid is low; eof is low.
- tx_afull is sampled only on trigger. A frame in progress always completes; the TGE FIFO headroom is at least MAX_LEN words.
- pkt_sim_enable falling mid-frame: the frame completes, then no further triggers.
- pkt_sim_period or payload length changing mid-frame: no effect on the current frame.
- pkt_sim_rst high:
  - pkt_count, skip_count and tmr are cleared to 0, and triggers are suppressed.
  - An in-flight frame completes with its latched seq_q.
  - pkt_sim_rst takes priority over a simultaneous accept/skip increment.
- busy = (state == SEND).

Decomposition:
- Package pkt_sim_pkg:
  - state enum {IDLE, SEND}
  - DATA_W/CNT_W/MAX_LEN defaults
  - length-clamp function
- Sub-module pkt_sim_period_timer: tmr and trigger generation.
- The FSM, word counter and status counters stay in the top module.

Test Plan:
- len=4, period=10, enable at cycle 0:
  - Words {0,0},{0,1},{0,2},{0,3} in cycles 1-4, eof in cycle 4.
  - Next frame seq 1 in cycles 11-14.
  - skip_count stays 0.
- len=4, period=3, run 12 cycles:
  - Triggers at 0,3,6,9; accepts at 0 and 6, skips at 3 and 9.
  - pkt_count=2, skip_count=2.
- Length clamping:
  - len=0 -> single word with tx_valid and eof both high.
  - len=5000 (MAX_LEN=1024) -> exactly 1024 words, eof on word 1023.
- Backpressure:
  - tx_afull=1 at trigger -> no tx_valid for that period, skip_count+1.
  - tx_afull rising at word 1 of an 8-word frame -> all 8 words still sent.
- Control edges:
  - period=0 with enable=1 for 100 cycles -> tx_valid never high.
  - enable dropped at word 2 of 6 -> words 3-5 still sent, then idle.
  - pkt_sim_rst pulse -> both counters 0, next frame seq 0.
- user_rst_n asserted mid-frame:
  - All outputs 0 in the same cycle.
  - After release, the first frame carries seq 0.
